fetch_unit: RTL

Instruction fetch stage feeding the instruction decoder. Holds the program counter, issues sequential word fetches to instruction memory over a request/grant/response handshake, and buffers returned words with their PC in a small in-order FIFO. Presents one instruction at a time to the decode stage under valid/ready. Accepts a redirect from execute (branch/jump) that flushes all in-flight and buffered instructions.

---
 rtl/fetch_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem request/response handshake, in-order {pc, word} FIFO toward decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,           // async, active-low
    output logic        imem_req,        // held with imem_addr until imem_gnt
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,     // in-order responses
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,  // single-cycle flush + new PC
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic          start_q;

    // Decode-side FIFO of returned words with their PCs.
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_word [DEPTH];
    logic [AW-1:0] fifo_wr;
    logic [AW-1:0] fifo_rd;

    // PCs of granted requests, in issue order; the head belongs to the next response.
    logic [31:0]   req_pc [DEPTH];
    logic [AW-1:0] req_wr;
    logic [AW-1:0] req_rd;

    logic          credit_ok;
    logic          grant;
    logic          rsp;
    logic          rsp_keep;
    logic          pop;
    logic [CW-1:0] outstanding_nxt;
    logic [1:0]    unused_redirect_lsbs;

    assign unused_redirect_lsbs = redirect_pc[1:0];

    // Outstanding fetches plus buffered words never exceed DEPTH, so a push always has room.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, count}) < DEPTH_C;
    assign imem_req  = start_q & ~redirect_valid & credit_ok;
    assign imem_addr = fetch_pc;
    assign grant     = imem_req & imem_gnt;

    // A response with nothing outstanding is a protocol violation and is ignored
    // (discard <= outstanding always holds, so this also covers discard == 0).
    assign rsp      = imem_rvalid & (outstanding != '0);
    assign rsp_keep = rsp & (discard == '0) & ~redirect_valid;

    assign outstanding_nxt = outstanding + CW'(grant) - CW'(rsp);

    assign instr_valid = (count != '0) & ~redirect_valid;
    assign instr       = fifo_word[fifo_rd];
    assign instr_pc    = fifo_pc[fifo_rd];
    assign pop         = instr_valid & instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            start_q     <= 1'b0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            req_wr      <= '0;
            req_rd      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_word[i] <= '0;
                req_pc[i]    <= '0;
            end
        end else begin
            start_q     <= 1'b1;
            outstanding <= outstanding_nxt;

            if (grant) begin
                fetch_pc       <= fetch_pc + 32'd4;
                req_pc[req_wr] <= fetch_pc;
                req_wr         <= req_wr + AW'(1);
            end
            if (rsp) begin
                req_rd <= req_rd + AW'(1);
            end

            if (redirect_valid) begin
                // No grant can occur here (imem_req is forced low), so this
                // PC update never competes with the increment above.
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                // Everything still in flight after this cycle's response belongs
                // to the old path and must be dropped when it returns.
                discard  <= outstanding_nxt;
                count    <= '0;
                fifo_wr  <= '0;
                fifo_rd  <= '0;
            end else begin
                if (rsp && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
                if (rsp_keep) begin
                    fifo_pc[fifo_wr]   <= req_pc[req_rd];
                    fifo_word[fifo_wr] <= imem_rdata;
                    fifo_wr            <= fifo_wr + AW'(1);
                end
                if (pop) begin
                    fifo_rd <= fifo_rd + AW'(1);
                end
                count <= count + CW'(rsp_keep) - CW'(pop);
            end
        end
    end
endmodule
